// File: rtl/pmu_pkg.sv
// Shared types and helpers for the PMU AXI-lite sampler.
package pmu_pkg;

  // Sweep FSM states.
  typedef enum logic [2:0] {
    StIdle,
    StAddr,
    StResp,
    StEmit,
    StDone
  } pmu_state_e;

  // AXI read response code for a successful access.
  localparam logic [1:0] RespOkay = 2'b00;

  // Byte offset of a PMU register: ({tile, reg} << align_w), with each index clipped to its
  // field width so an oversized index cannot spill into the neighbouring field.
  function automatic logic [63:0] pmu_reg_offset(input logic [31:0] tile,
                                                 input logic [31:0] reg_idx,
                                                 input int unsigned tile_w,
                                                 input int unsigned reg_w,
                                                 input int unsigned align_w);
    logic [63:0] t;
    logic [63:0] r;
    t = 64'(tile) & ((64'd1 << tile_w) - 64'd1);
    r = 64'(reg_idx) & ((64'd1 << reg_w) - 64'd1);
    return ((t << reg_w) | r) << align_w;
  endfunction

endpackage

// File: rtl/pmu_axi_sampler.sv
// Walks every PMU register of every tile over AXI-lite reads (one outstanding at a time) and
// streams each value out with its tile/register index.
module pmu_axi_sampler
  import pmu_pkg::*;
#(
  parameter int unsigned DATA_WIDTH         = 64,
  parameter int unsigned ADDRESS_WIDTH      = 64,
  parameter int unsigned TILE_COUNT         = 1,
  parameter int unsigned EVENT_SIGNAL_COUNT = 25,
  parameter int unsigned ADDR_REG_WIDTH     = 6,
  parameter int unsigned ADDR_TILE_WIDTH    = 7,
  parameter int unsigned ADDR_ALIGN_WIDTH   = 3,
  parameter int unsigned TIMEOUT_CYCLES     = 1024
) (
  input  logic                       noc_clk,
  input  logic                       rst,
  input  logic                       start_i,
  input  logic [ADDRESS_WIDTH-1:0]   base_addr_i,
  output logic                       busy_o,
  output logic                       done_o,
  output logic                       err_o,
  output logic [ADDRESS_WIDTH-1:0]   m_axi_araddr,
  output logic [2:0]                 m_axi_arprot,
  output logic                       m_axi_arvalid,
  input  logic                       m_axi_arready,
  input  logic [DATA_WIDTH-1:0]      m_axi_rdata,
  input  logic [1:0]                 m_axi_rresp,
  input  logic                       m_axi_rvalid,
  output logic                       m_axi_rready,
  output logic                       m_axi_awvalid,
  output logic                       m_axi_wvalid,
  output logic                       m_axi_bready,
  output logic                       sample_valid_o,
  input  logic                       sample_ready_i,
  output logic [ADDR_TILE_WIDTH-1:0] sample_tile_o,
  output logic [ADDR_REG_WIDTH-1:0]  sample_reg_o,
  output logic [DATA_WIDTH-1:0]      sample_data_o,
  output logic                       sample_last_o
);

  // Index counters hold TILE_COUNT / EVENT_SIGNAL_COUNT without wrapping.
  localparam int unsigned TileW = $clog2(TILE_COUNT + 1);
  localparam int unsigned RegW  = $clog2(EVENT_SIGNAL_COUNT + 1);
  // One extra value of headroom: a late AR handshake may land exactly on the limit.
  localparam int unsigned TmoW  = $clog2(TIMEOUT_CYCLES + 2);

  localparam logic [TileW-1:0] TileLast = TileW'(TILE_COUNT - 1);
  localparam logic [RegW-1:0]  RegLast  = RegW'(EVENT_SIGNAL_COUNT);
  localparam logic [TmoW-1:0]  TmoLimit = TmoW'(TIMEOUT_CYCLES);

  pmu_state_e               state_q;
  logic [ADDRESS_WIDTH-1:0] base_q;
  logic [TileW-1:0]         tile_q;
  logic [RegW-1:0]          reg_q;
  logic [TmoW-1:0]          tmo_q;

  logic                       busy_q;
  logic                       done_q;
  logic                       err_q;
  logic [ADDRESS_WIDTH-1:0]   araddr_q;
  logic                       arvalid_q;
  logic                       rready_q;
  logic                       svalid_q;
  logic [ADDR_TILE_WIDTH-1:0] stile_q;
  logic [ADDR_REG_WIDTH-1:0]  sreg_q;
  logic [DATA_WIDTH-1:0]      sdata_q;
  logic                       slast_q;

  logic                       is_last;
  logic [TileW-1:0]           tile_nxt;
  logic [RegW-1:0]            reg_nxt;
  logic [ADDRESS_WIDTH-1:0]   araddr_nxt;
  logic [TmoW-1:0]            tmo_inc;
  logic                       tmo_hit;

  // Next register in tile-major, register-ascending order, and the address it lives at.
  always_comb begin
    is_last  = (tile_q == TileLast) && (reg_q == RegLast);
    tile_nxt = tile_q;
    reg_nxt  = reg_q + RegW'(1);
    if (reg_q == RegLast) begin
      tile_nxt = tile_q + TileW'(1);
      reg_nxt  = '0;
    end
    araddr_nxt = base_q + ADDRESS_WIDTH'(pmu_reg_offset(32'(tile_nxt), 32'(reg_nxt),
                                                        ADDR_TILE_WIDTH, ADDR_REG_WIDTH,
                                                        ADDR_ALIGN_WIDTH));
    tmo_inc = tmo_q + TmoW'(1);
    tmo_hit = tmo_inc >= TmoLimit;
  end

  // Sweep FSM with index/timeout counters and registered outputs.
  always_ff @(posedge noc_clk) begin
    if (!rst) begin
      state_q   <= StIdle;
      base_q    <= '0;
      tile_q    <= '0;
      reg_q     <= '0;
      tmo_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      araddr_q  <= '0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      svalid_q  <= 1'b0;
      stile_q   <= '0;
      sreg_q    <= '0;
      sdata_q   <= '0;
      slast_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start_i) begin
            base_q    <= base_addr_i;
            tile_q    <= '0;
            reg_q     <= '0;
            tmo_q     <= '0;
            err_q     <= 1'b0;
            araddr_q  <= base_addr_i;
            arvalid_q <= 1'b1;
            busy_q    <= 1'b1;
            state_q   <= StAddr;
          end
        end
        StAddr: begin
          tmo_q <= tmo_inc;
          if (m_axi_arready) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            state_q   <= StResp;
          end else if (tmo_hit) begin
            arvalid_q <= 1'b0;
            err_q     <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
            state_q   <= StDone;
          end
        end
        StResp: begin
          tmo_q <= tmo_inc;
          if (m_axi_rvalid) begin
            rready_q <= 1'b0;
            svalid_q <= 1'b1;
            stile_q  <= ADDR_TILE_WIDTH'(tile_q);
            sreg_q   <= ADDR_REG_WIDTH'(reg_q);
            sdata_q  <= m_axi_rdata;
            slast_q  <= is_last;
            if (m_axi_rresp != RespOkay) err_q <= 1'b1;
            state_q  <= StEmit;
          end else if (tmo_hit) begin
            // Abandon the read: no sample is produced for this register.
            rready_q <= 1'b0;
            err_q    <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            state_q  <= StDone;
          end
        end
        StEmit: begin
          if (sample_ready_i) begin
            svalid_q <= 1'b0;
            if (is_last) begin
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= StDone;
            end else begin
              tile_q    <= tile_nxt;
              reg_q     <= reg_nxt;
              tmo_q     <= '0;
              araddr_q  <= araddr_nxt;
              arvalid_q <= 1'b1;
              state_q   <= StAddr;
            end
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign busy_o         = busy_q;
  assign done_o         = done_q;
  assign err_o          = err_q;
  assign m_axi_araddr   = araddr_q;
  assign m_axi_arprot   = 3'b000;
  assign m_axi_arvalid  = arvalid_q;
  assign m_axi_rready   = rready_q;
  assign m_axi_awvalid  = 1'b0;
  assign m_axi_wvalid   = 1'b0;
  assign m_axi_bready   = 1'b1;
  assign sample_valid_o = svalid_q;
  assign sample_tile_o  = stile_q;
  assign sample_reg_o   = sreg_q;
  assign sample_data_o  = sdata_q;
  assign sample_last_o  = slast_q;

endmodule

// File: tb/tb_pmu_axi_sampler.sv
// Directed bench for pmu_axi_sampler: two tiles of four registers, a zero-latency AXI-lite
// slave that returns the read address as data, and a scoreboard of expected samples.
module tb_pmu_axi_sampler;

  localparam logic [63:0] Base = 64'h0000_00FF_F500_0000;

  logic        noc_clk = 1'b0;
  logic        rst;
  logic        start_i;
  logic [63:0] base_addr_i;
  logic        busy_o, done_o, err_o;
  logic [63:0] m_axi_araddr;
  logic [2:0]  m_axi_arprot;
  logic        m_axi_arvalid, m_axi_arready;
  logic [63:0] m_axi_rdata;
  logic [1:0]  m_axi_rresp;
  logic        m_axi_rvalid, m_axi_rready;
  logic        m_axi_awvalid, m_axi_wvalid, m_axi_bready;
  logic        sample_valid_o, sample_ready_i;
  logic [6:0]  sample_tile_o;
  logic [5:0]  sample_reg_o;
  logic [63:0] sample_data_o;
  logic        sample_last_o;

  pmu_axi_sampler #(
    .DATA_WIDTH        (64),
    .ADDRESS_WIDTH     (64),
    .TILE_COUNT        (2),
    .EVENT_SIGNAL_COUNT(3),
    .ADDR_REG_WIDTH    (6),
    .ADDR_TILE_WIDTH   (7),
    .ADDR_ALIGN_WIDTH  (3),
    .TIMEOUT_CYCLES    (16)
  ) dut (
    .noc_clk       (noc_clk),
    .rst           (rst),
    .start_i       (start_i),
    .base_addr_i   (base_addr_i),
    .busy_o        (busy_o),
    .done_o        (done_o),
    .err_o         (err_o),
    .m_axi_araddr  (m_axi_araddr),
    .m_axi_arprot  (m_axi_arprot),
    .m_axi_arvalid (m_axi_arvalid),
    .m_axi_arready (m_axi_arready),
    .m_axi_rdata   (m_axi_rdata),
    .m_axi_rresp   (m_axi_rresp),
    .m_axi_rvalid  (m_axi_rvalid),
    .m_axi_rready  (m_axi_rready),
    .m_axi_awvalid (m_axi_awvalid),
    .m_axi_wvalid  (m_axi_wvalid),
    .m_axi_bready  (m_axi_bready),
    .sample_valid_o(sample_valid_o),
    .sample_ready_i(sample_ready_i),
    .sample_tile_o (sample_tile_o),
    .sample_reg_o  (sample_reg_o),
    .sample_data_o (sample_data_o),
    .sample_last_o (sample_last_o)
  );

  always #5 noc_clk = ~noc_clk;

  // ---------------- slave model ----------------
  logic        hang_en = 1'b0, err_en = 1'b0;
  logic [63:0] hang_addr = '0, err_addr = '0;
  logic        pend_q;
  logic [63:0] paddr_q;

  always @(posedge noc_clk) begin
    if (!rst) begin
      pend_q  <= 1'b0;
      paddr_q <= '0;
    end else if (m_axi_arvalid && m_axi_arready) begin
      pend_q  <= 1'b1;
      paddr_q <= m_axi_araddr;
    end else if (m_axi_rvalid && m_axi_rready) begin
      pend_q  <= 1'b0;
    end
  end

  assign m_axi_arready = 1'b1;
  assign m_axi_rvalid  = pend_q && !(hang_en && paddr_q == hang_addr);
  assign m_axi_rdata   = paddr_q;
  assign m_axi_rresp   = (err_en && paddr_q == err_addr) ? 2'b10 : 2'b00;

  // ---------------- scoreboard ----------------
  typedef struct {
    logic [6:0]  tile;
    logic [5:0]  r;
    logic [63:0] data;
    logic        last;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   sample_cnt = 0, last_cnt = 0, done_cnt = 0, ar_cnt = 0;
  int   hang_cyc = -1000, done_cyc = 0;

  task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_sweep(input logic [63:0] base, input int ntiles);
    exp_t e;
    for (int t = 0; t < ntiles; t++) begin
      for (int r = 0; r < 4; r++) begin
        e.tile = 7'(t);
        e.r    = 6'(r);
        e.data = base + 64'(t) * 64'h200 + 64'(r) * 64'h8;
        e.last = (t == 1) && (r == 3);
        exp_q.push_back(e);
      end
    end
  endtask

  always @(posedge noc_clk) cyc <= cyc + 1;

  // Protocol and output monitor, sampled mid-cycle.
  always @(negedge noc_clk) begin
    exp_t e;
    if (m_axi_arvalid || m_axi_rready)
      check("ar_r_exclusive", 96'(m_axi_arvalid & m_axi_rready), 96'd0);
    if (m_axi_arvalid && m_axi_arready) begin
      ar_cnt++;
      if (hang_en && m_axi_araddr == hang_addr) hang_cyc = cyc;
    end
    if (done_o) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (sample_valid_o && sample_ready_i) begin
      sample_cnt++;
      if (sample_last_o) last_cnt++;
      check("sample_expected", 96'(exp_q.size() != 0), 96'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("sample_tile", 96'(sample_tile_o), 96'(e.tile));
        check("sample_reg", 96'(sample_reg_o), 96'(e.r));
        check("sample_data", 96'(sample_data_o), 96'(e.data));
        check("sample_last", 96'(sample_last_o), 96'(e.last));
      end
    end
  end

  // ---------------- directed sequence ----------------
  task automatic step();
    @(posedge noc_clk);
    #1;
  endtask

  task automatic start_sweep(input logic [63:0] base);
    start_i     = 1'b1;
    base_addr_i = base;
    step();
    start_i     = 1'b0;
  endtask

  task automatic wait_done(input int limit);
    int n = 0;
    while (!done_o && n < limit) begin
      step();
      n++;
    end
    check("sweep_done", 96'(done_o), 96'd1);
  endtask

  task automatic check_idle_outputs(input string tag);
    logic [13:0] flags;
    flags = {busy_o, done_o, err_o, m_axi_arvalid, |m_axi_araddr, |m_axi_arprot, m_axi_rready,
             m_axi_awvalid, m_axi_wvalid, sample_valid_o, |sample_tile_o, |sample_reg_o,
             |sample_data_o, sample_last_o};
    check(tag, 96'(flags), 96'd0);
    check({tag, "_bready"}, 96'(m_axi_bready), 96'd1);
  endtask

  initial begin
    int s0, l0, d0, a0, n, seen;
    logic [78:0] held;

    rst = 1'b0; start_i = 1'b0; base_addr_i = '0; sample_ready_i = 1'b1;
    repeat (3) step();
    check_idle_outputs("reset_outputs");
    rst = 1'b1;
    step();

    // Plain sweep: 8 samples, address == data, one last, one done pulse.
    s0 = sample_cnt; l0 = last_cnt; d0 = done_cnt;
    push_sweep(Base, 2);
    start_sweep(Base);
    check("start_busy", 96'(busy_o), 96'd1);
    wait_done(200);
    check("done_not_busy", 96'(busy_o), 96'd0);
    step(); step();
    check("s1_samples", 96'(sample_cnt - s0), 96'd8);
    check("s1_last", 96'(last_cnt - l0), 96'd1);
    check("s1_done_pulse", 96'(done_cnt - d0), 96'd1);
    check("s1_queue_empty", 96'(exp_q.size()), 96'd0);
    check("s1_no_err", 96'(err_o), 96'd0);

    // Backpressure: hold sample 3 for 20 cycles.
    s0 = sample_cnt;
    sample_ready_i = 1'b0;
    push_sweep(Base, 2);
    start_sweep(Base);
    for (int k = 0; k < 8; k++) begin
      n = 0;
      while (!sample_valid_o && n < 50) begin
        step();
        n++;
      end
      check("bp_valid", 96'(sample_valid_o), 96'd1);
      if (k == 2) begin
        held = {sample_valid_o, sample_tile_o, sample_reg_o, sample_data_o, sample_last_o};
        a0 = ar_cnt;
        repeat (20) begin
          step();
          check("bp_hold", 96'({sample_valid_o, sample_tile_o, sample_reg_o, sample_data_o,
                                sample_last_o}), 96'(held));
        end
        check("bp_no_ar", 96'(ar_cnt - a0), 96'd0);
      end
      sample_ready_i = 1'b1;
      step();
      sample_ready_i = 1'b0;
    end
    sample_ready_i = 1'b1;
    wait_done(50);
    step();
    check("bp_samples", 96'(sample_cnt - s0), 96'd8);
    check("bp_queue_empty", 96'(exp_q.size()), 96'd0);

    // SLVERR on tile 0 reg 2: sticky error, sweep still completes.
    s0 = sample_cnt;
    err_en = 1'b1; err_addr = Base + 64'h10;
    push_sweep(Base, 2);
    start_sweep(Base);
    seen = 0; n = 0;
    while (!done_o && n < 200) begin
      if (sample_valid_o && sample_tile_o == 7'd0 && sample_reg_o == 6'd1)
        check("err_before", 96'(err_o), 96'd0);
      if (sample_valid_o && sample_tile_o == 7'd0 && sample_reg_o == 6'd2) begin
        check("err_at_sample", 96'(err_o), 96'd1);
        seen = 1;
      end
      step();
      n++;
    end
    check("sweep_done", 96'(done_o), 96'd1);
    check("err_sample_seen", 96'(seen), 96'd1);
    check("err_sticky", 96'(err_o), 96'd1);
    err_en = 1'b0;
    step();
    check("err_samples", 96'(sample_cnt - s0), 96'd8);
    check("err_idle_sticky", 96'(err_o), 96'd1);

    // Next start clears err; starts mid-sweep and in DONE are ignored.
    s0 = sample_cnt; d0 = done_cnt;
    push_sweep(Base, 2);
    start_sweep(Base);
    check("err_cleared", 96'(err_o), 96'd0);
    repeat (5) step();
    start_i = 1'b1; base_addr_i = 64'h1234_0000;
    step();
    start_i = 1'b0;
    wait_done(200);
    start_i = 1'b1;
    step();
    start_i = 1'b0;
    check("done_start_ignored", 96'(busy_o), 96'd0);
    repeat (20) step();
    check("ign_still_idle", 96'(busy_o), 96'd0);
    check("ign_samples", 96'(sample_cnt - s0), 96'd8);
    check("ign_done_pulse", 96'(done_cnt - d0), 96'd1);
    check("ign_queue_empty", 96'(exp_q.size()), 96'd0);

    // Timeout: slave never answers tile 1 reg 0.
    s0 = sample_cnt; l0 = last_cnt;
    hang_en = 1'b1; hang_addr = Base + 64'h200;
    push_sweep(Base, 1);
    start_sweep(Base);
    wait_done(200);
    step();
    check("to_cycles", 96'(done_cyc - hang_cyc), 96'd16);
    check("to_err", 96'(err_o), 96'd1);
    check("to_samples", 96'(sample_cnt - s0), 96'd4);
    check("to_no_last", 96'(last_cnt - l0), 96'd0);
    check("to_queue_empty", 96'(exp_q.size()), 96'd0);
    hang_en = 1'b0;

    // Reset while a read is outstanding, then a clean sweep.
    s0 = sample_cnt;
    start_sweep(Base);
    n = 0;
    while (!m_axi_rready && n < 20) begin
      step();
      n++;
    end
    check("rst_resp_reached", 96'(m_axi_rready), 96'd1);
    rst = 1'b0;
    step();
    rst = 1'b1;
    check_idle_outputs("rst_resp_outputs");
    step();
    check("rst_stays_idle", 96'(busy_o), 96'd0);
    check("rst_no_sample", 96'(sample_cnt - s0), 96'd0);
    push_sweep(Base, 2);
    start_sweep(Base);
    wait_done(200);
    step();
    check("post_rst_samples", 96'(sample_cnt - s0), 96'd8);
    check("post_rst_queue", 96'(exp_q.size()), 96'd0);
    check("post_rst_err", 96'(err_o), 96'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
